// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the two-port memory arbiter.
//   - FSM state encoding (IDLE / GRANT0 / GRANT1)
//   - default block address and data widths
//   - is_req(): a port is requesting when either strobe is high
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  localparam int ARB_ADDR_W = 6;   // 8-bit byte address minus 2-bit offset
  localparam int ARB_DATA_W = 32;  // one block per transfer

  function automatic logic is_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: block memory bus (read/write/address/writedata/readdata/
// busywait), the same protocol the data memory exposes.
//   master modport: drives read, write, address, writedata;
//                   receives readdata, busywait
//   slave modport : the opposite direction
// The arbiter is a slave towards each cache and a master towards memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// arb_rr2: two-requester grant picker.
// Ports:
//   i_req0, i_req1 : request from port 0 (dcache) / port 1 (icache)
//   i_last         : port served most recently
//   o_valid        : at least one request present
//   o_grant        : chosen port (0 or 1), meaningful when o_valid
// Macro MEM_ARB_FIXED_PRIORITY_EN: when defined, port 0 wins every tie and
// i_last is ignored; otherwise a tie goes to the port that was not served last.
module arb_rr2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_grant
);

  assign o_valid = i_req0 | i_req1;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_grant       = ~i_req0;
`else
  always_comb begin
    if (i_req0 & i_req1) o_grant = ~i_last;
    else                 o_grant = i_req1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block data memory between the data cache (p0)
// and the instruction cache (p1). Transfers are serialized; ties are
// resolved round-robin by default.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   p0, p1     : cache-side buses (slave modport); readdata is registered,
//                busywait is combinational
//   mem        : data-memory-side bus (master modport)
// Macro MEM_ARB_FIXED_PRIORITY_EN: port 0 always wins a tie (see arb_rr2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem
);

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_issued;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic              w_req0;
  logic              w_req1;
  logic              w_pick_vld;
  logic              w_pick;
  logic              w_in_g0;
  logic              w_in_g1;
  logic              w_done;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_req0  = is_req(p0.read, p0.write);
  assign w_req1  = is_req(p1.read, p1.write);
  assign w_in_g0 = (r_state == GRANT0);
  assign w_in_g1 = (r_state == GRANT1);

  arb_rr2 u_pick (
    .i_req0  (w_req0),
    .i_req1  (w_req1),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_grant (w_pick)
  );

  // Granted port is forwarded straight through; write wins over read. If the
  // requester drops its strobes mid-grant, zeros are forwarded naturally.
  always_comb begin
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_address = '0;
    w_mem_wdata   = '0;
    if (w_in_g0) begin
      w_mem_read    = p0.read & ~p0.write;
      w_mem_write   = p0.write;
      w_mem_address = p0.address;
      w_mem_wdata   = p0.writedata;
    end else if (w_in_g1) begin
      w_mem_read    = p1.read & ~p1.write;
      w_mem_write   = p1.write;
      w_mem_address = p1.address;
      w_mem_wdata   = p1.writedata;
    end
  end

  assign mem.read      = w_mem_read;
  assign mem.write     = w_mem_write;
  assign mem.address   = w_mem_address;
  assign mem.writedata = w_mem_wdata;

  // The first grant cycle only presents the strobe; memory busywait is not
  // trusted until the following cycle (r_issued).
  assign w_done = r_issued & ~mem.busywait;

  // Busywait drops in the completion cycle, one edge before readdata is
  // captured; requesters sample readdata on a later edge.
  assign p0.busywait = w_req0 & ~(w_in_g0 & w_done);
  assign p1.busywait = w_req1 & ~(w_in_g1 & w_done);
  assign p0.readdata = r_p0_rdata;
  assign p1.readdata = r_p1_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_issued   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_issued <= 1'b0;
          if (w_pick_vld) r_state <= w_pick ? GRANT1 : GRANT0;
        end
        GRANT0, GRANT1: begin
          r_issued <= 1'b1;
          if (w_done) begin
            r_state <= IDLE;
            r_last  <= w_in_g1;
            if (w_mem_read) begin
              if (w_in_g1) r_p1_rdata <= mem.readdata;
              else         r_p0_rdata <= mem.readdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if p0_if ();
  mem_arbiter_if p1_if ();
  mem_arbiter_if mem_if ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .p0    (p0_if),
    .p1    (p1_if),
    .mem   (mem_if)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   order_q[$];
  logic model_last = 1'b1;
  int   lat = 1;

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'hC0DE0000 | a;
  endfunction

  // Block memory: busywait rises with a strobe, data moves after lat edges.
  logic [31:0] mem_arr [0:63];
  logic [31:0] ref_mem [0:63];
  int          mcnt;
  logic        mack;

  assign mem_if.busywait = (mem_if.read | mem_if.write) & ~mack;

  always @(posedge clk) begin
    if (reset) begin
      mcnt <= 0;
      mack <= 1'b0;
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else if ((mem_if.read | mem_if.write) && !mack) begin
      if (mcnt + 1 >= lat) begin
        mack <= 1'b1;
        mcnt <= 0;
        if (mem_if.write) mem_arr[mem_if.address] <= mem_if.writedata;
        else              mem_if.readdata <= mem_arr[mem_if.address];
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mack <= 1'b0;
      mcnt <= 0;
    end
  end

  // After any completion cycle the next cycle must carry no memory strobe.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset && prev_done) begin
      n_chk++;
      if (mem_if.read | mem_if.write) begin
        n_fail++;
        $display("FAIL no_back_to_back: mem_read=%b mem_write=%b, want 0 0", mem_if.read, mem_if.write);
      end
    end
    prev_done = !reset && ((((p0_if.read | p0_if.write) & ~p0_if.busywait) === 1'b1) ||
                           (((p1_if.read | p1_if.write) & ~p1_if.busywait) === 1'b1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ref_reset;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic drive(input int port, input logic rd, input logic wr,
                       input logic [5:0] a, input logic [31:0] d);
    if (port == 0) begin
      p0_if.read = rd; p0_if.write = wr; p0_if.address = a; p0_if.writedata = d;
    end else begin
      p1_if.read = rd; p1_if.write = wr; p1_if.address = a; p1_if.writedata = d;
    end
  endtask

  // One block transfer on one port, entered and left at a negedge.
  task automatic xfer(input int port, input logic rd, input logic wr,
                      input logic [5:0] addr, input logic [31:0] wd, output int cyc);
    logic [31:0] old_rd, exp_rd, got;
    logic        seen, done;
    old_rd = (port == 0) ? p0_if.readdata : p1_if.readdata;
    drive(port, rd, wr, addr, wd);
    seen = 1'b0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if ((mem_if.read == (rd & ~wr)) && (mem_if.write == wr) && (mem_if.address == addr) &&
          (!wr || mem_if.writedata == wd)) seen = 1'b1;
      done = (port == 0) ? ~p0_if.busywait : ~p1_if.busywait;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL xfer_timeout port%0d addr %h: busywait=1 after %0d cycles, want 0", port, addr, cyc);
      drive(port, 1'b0, 1'b0, addr, wd);
      return;
    end
    exp_rd = ref_mem[addr];
    if (wr) ref_mem[addr] = wd;
    order_q.push_back(port);
    model_last = (port != 0);
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mem_forward port%0d: no cycle with rd=%b wr=%b addr=%h wd=%h on mem bus",
               port, rd & ~wr, wr, addr, wd);
    end
    @(negedge clk);
    got = (port == 0) ? p0_if.readdata : p1_if.readdata;
    n_chk++;
    if (got !== ((rd & ~wr) ? exp_rd : old_rd)) begin
      n_fail++;
      $display("FAIL readdata port%0d addr %h: got %h want %h", port, addr, got,
               (rd & ~wr) ? exp_rd : old_rd);
    end
    drive(port, 1'b0, 1'b0, addr, wd);
  endtask

  task automatic test_reset;
    drive(0, 1'b1, 1'b0, 6'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 6'h00, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (p0_if.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_p0_readdata: got %h want 0", p0_if.readdata); end
    n_chk++; if (p1_if.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_p1_readdata: got %h want 0", p1_if.readdata); end
    n_chk++; if (mem_if.read !== 1'b0 || mem_if.write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b%b want 00", mem_if.read, mem_if.write); end
    n_chk++; if (mem_if.address !== 6'h0 || mem_if.writedata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_if.address, mem_if.writedata); end
    n_chk++; if (p0_if.busywait !== 1'b1) begin n_fail++; $display("FAIL reset_p0_busywait: got %b want 1", p0_if.busywait); end
    n_chk++; if (p1_if.busywait !== 1'b0) begin n_fail++; $display("FAIL reset_p1_busywait: got %b want 0", p1_if.busywait); end
    drive(0, 1'b0, 1'b0, 6'h00, 32'h0);
    ref_reset();
    model_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_simultaneous;
    int c0, c1, base;
    lat  = 3;
    base = order_q.size();
    @(negedge clk);
    fork
      xfer(0, 1'b1, 1'b0, 6'd10, 32'h0, c0);
      xfer(1, 1'b1, 1'b0, 6'd20, 32'h0, c1);
    join
    n_chk++;
    if (order_q.size() != base + 2) begin
      n_fail++; $display("FAIL simul_count: got %0d transfers want 2", order_q.size() - base);
    end else if (order_q[base] != 0 || order_q[base+1] != 1) begin
      n_fail++; $display("FAIL simul_order: got %0d,%0d want 0,1", order_q[base], order_q[base+1]);
    end
    n_chk++; if (c0 != 1 + lat) begin n_fail++; $display("FAIL simul_p0_cycles: got %0d want %0d", c0, 1 + lat); end
    n_chk++; if (c1 != 3 + 2 * lat) begin n_fail++; $display("FAIL simul_p1_busy_cycles: got %0d want %0d", c1, 3 + 2 * lat); end
  endtask

  task automatic test_single_read;
    int c;
    logic [31:0] p1_old;
    lat = 5;
    @(negedge clk);
    p1_old = p1_if.readdata;
    xfer(0, 1'b1, 1'b0, 6'h05, 32'h0, c);
    n_chk++; if (c != 1 + lat) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want %0d", c, 1 + lat); end
    n_chk++; if (p0_if.readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_readdata: got %h want deadbeef", p0_if.readdata); end
    n_chk++; if (p1_if.readdata !== p1_old) begin n_fail++; $display("FAIL single_p1_untouched: got %h want %h", p1_if.readdata, p1_old); end
  endtask

  task automatic test_write;
    int c;
    lat = 2;
    @(negedge clk);
    xfer(1, 1'b0, 1'b1, 6'h3F, 32'h12345678, c);
    xfer(0, 1'b1, 1'b0, 6'h3F, 32'h0, c);
    n_chk++; if (p0_if.readdata !== 32'h12345678) begin n_fail++; $display("FAIL write_readback: got %h want 12345678", p0_if.readdata); end
  endtask

  task automatic test_collision;
    int c;
    lat = 2;
    @(negedge clk);
    xfer(0, 1'b1, 1'b1, 6'h09, 32'hA5A50F0F, c);
    xfer(1, 1'b1, 1'b0, 6'h09, 32'h0, c);
    n_chk++; if (p1_if.readdata !== 32'hA5A50F0F) begin n_fail++; $display("FAIL collision_readback: got %h want a5a50f0f", p1_if.readdata); end
  endtask

  task automatic test_fairness;
    int base, first, expv;
    lat  = 2;
    base = order_q.size();
    @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    first = 0;
`else
    first = model_last ? 0 : 1;
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int ca;
          xfer(0, 1'b1, 1'b0, 6'(i), 32'h0, ca);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int cb;
          xfer(1, 1'b1, 1'b0, 6'(j + 8), 32'h0, cb);
        end
      end
    join
    n_chk++;
    if (order_q.size() != base + 8) begin
      n_fail++; $display("FAIL fair_count: got %0d transfers want 8", order_q.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        expv = first;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        if (k % 2 == 1) expv = 1 - first;
`endif
        n_chk++;
        if (order_q[base+k] != expv) begin
          n_fail++; $display("FAIL fair_order[%0d]: got port%0d want port%0d", k, order_q[base+k], expv);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int   c;
    logic done;
    lat = 10;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 6'h07, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (mem_if.read !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_read: got %b want 0", mem_if.read); end
    n_chk++; if (p0_if.readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_p0_readdata: got %h want 0", p0_if.readdata); end
    n_chk++; if (p1_if.readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_p1_readdata: got %h want 0", p1_if.readdata); end
    n_chk++; if (p0_if.busywait !== 1'b1) begin n_fail++; $display("FAIL midreset_p0_busywait: got %b want 1", p0_if.busywait); end
    ref_reset();
    model_last = 1'b1;
    reset = 1'b0;
    c = 0;
    done = 1'b0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      done = ~p0_if.busywait;
    end
    n_chk++;
    if (!done || c != 1 + lat) begin
      n_fail++; $display("FAIL midreset_regrant: done=%b after %0d cycles, want 1 after %0d", done, c, 1 + lat);
    end
    @(negedge clk);
    n_chk++; if (p0_if.readdata !== ref_mem[7]) begin n_fail++; $display("FAIL midreset_readdata: got %h want %h", p0_if.readdata, ref_mem[7]); end
    order_q.push_back(0);
    model_last = 1'b0;
    drive(0, 1'b0, 1'b0, 6'h07, 32'h0);
  endtask

  task automatic test_random;
    for (int b = 0; b < 10; b++) begin
      lat = $urandom_range(1, 4);
      @(negedge clk);
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            int op, ca;
            op = $urandom_range(0, 2);
            xfer(0, op != 1, op != 0, 6'($urandom_range(0, 7)), $urandom, ca);
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end
        begin
          for (int j = 0; j < 4; j++) begin
            int op, cb;
            op = $urandom_range(0, 2);
            xfer(1, op != 1, op != 0, 6'($urandom_range(0, 7)), $urandom, cb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end
      join
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single_read();
    test_write();
    test_collision();
    test_fairness();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
